// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Ball position/speed, wall and paddle rebound, miss detection with score
//   pulses, serve state machine, and a registered 1-bit-per-channel ball
//   overlay for the VGA mixer. Motion advances only on i_frame_tick.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_frame_tick             one-cycle pulse per frame (outside visible area)
//   i_pixel_x/y, i_visible   current raster position and visibility
//   i_paddle1_y/i_paddle2_y  top row of left/right paddle
//   i_serve                  serve request (level), honoured in IDLE only
//   o_r/o_g/o_b              ball pixel (white), 1-cycle latency
//   o_ball_x/o_ball_y        registered ball top-left corner
//   o_score_p1/o_score_p2    one-cycle pulse: right/left player missed
//   o_state                  IDLE=0, SERVE=1, PLAY=2, SCORED=3
//
// Optional feature: define PONG_BALL_SPIN_EN to let the paddle hit point
// (top/middle/bottom third) steer the vertical direction.
module pong_ball_engine #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int BALL_W        = 8,
    parameter int BALL_H        = 10,
    parameter int PADDLE_MARGIN = 30,
    parameter int PADDLE_W      = 10,
    parameter int PADDLE_H      = 50,
    parameter int SPEED_X_INIT  = 2,
    parameter int SPEED_X_MAX   = 6,
    parameter int SPEED_Y       = 2,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic       i_visible,
    input  logic [9:0] i_paddle1_y,
    input  logic [9:0] i_paddle2_y,
    input  logic       i_serve,
    output logic       o_r,
    output logic       o_g,
    output logic       o_b,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_score_p1,
    output logic       o_score_p2,
    output logic [1:0] o_state
);
    localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam int VW = $clog2(SPEED_X_MAX + 2);

    localparam logic [9:0]    X_CTR   = 10'((SCREEN_W - BALL_W) / 2);
    localparam logic [9:0]    Y_CTR   = 10'((SCREEN_H - BALL_H) / 2);
    localparam logic [10:0]   HIT_R   = 11'(SCREEN_W - PADDLE_MARGIN - PADDLE_W - BALL_W);
    localparam logic [10:0]   HIT_L   = 11'(PADDLE_MARGIN + PADDLE_W);
    localparam logic [VW-1:0] VX_INIT = VW'(SPEED_X_INIT);
    localparam logic [VW-1:0] VX_MAX  = VW'(SPEED_X_MAX);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_SCORED = 2'd3} state_t;

    state_t          r_state, w_state;
    logic [9:0]      r_x, r_y, w_x, w_y;
    logic [VW-1:0]   r_vx, w_vx;
    logic            r_xdir, w_xdir;   // 1 = right
    logic            r_ydir, w_ydir;   // 1 = down
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_s1, r_s2, w_s1, w_s2;
    logic            r_rgb, w_rgb;

    // All compares on 11-bit zero-extended operands so sums never wrap.
    logic [10:0] w_x11, w_y11, w_vx11, w_pad11;
    logic        w_overlap, w_hit;

    assign w_x11     = {1'b0, r_x};
    assign w_y11     = {1'b0, r_y};
    assign w_vx11    = 11'(r_vx);
    assign w_pad11   = {1'b0, (r_xdir ? i_paddle2_y : i_paddle1_y)};
    assign w_overlap = (w_y11 + 11'(BALL_H) > w_pad11) && (w_y11 < w_pad11 + 11'(PADDLE_H));
    assign w_hit     = w_overlap && (r_xdir ? (w_x11 >= HIT_R) : (w_x11 <= HIT_L));

    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_vx    = r_vx;
        w_xdir  = r_xdir;
        w_ydir  = r_ydir;
        w_cnt   = r_cnt;
        w_s1    = 1'b0;
        w_s2    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_serve) begin
                    w_state = S_SERVE;
                    w_cnt   = '0;
                end
            end
            S_SERVE: begin
                if (i_frame_tick) begin
                    if (r_cnt == CW'(SERVE_FRAMES - 1)) w_state = S_PLAY;
                    else                                 w_cnt   = r_cnt + CW'(1);
                end
            end
            S_PLAY: begin
                if (i_frame_tick) begin
                    // Y axis first; a paddle hit with spin may override its direction.
                    if (r_ydir) begin
                        if (w_y11 + 11'(BALL_H + SPEED_Y) >= 11'(SCREEN_H)) w_ydir = 1'b0;
                        else                                                 w_y    = r_y + 10'(SPEED_Y);
                    end else begin
                        if (w_y11 < 11'(SPEED_Y)) w_ydir = 1'b1;
                        else                      w_y    = r_y - 10'(SPEED_Y);
                    end
                    // X axis: paddle > miss > move.
                    if (w_hit) begin
                        w_xdir = ~r_xdir;
                        w_vx   = (r_vx >= VX_MAX) ? VX_MAX : r_vx + VW'(1);
`ifdef PONG_BALL_SPIN_EN
                        if (w_y11 + 11'(BALL_H / 2) < w_pad11 + 11'(PADDLE_H / 3))
                            w_ydir = 1'b0;
                        else if (w_y11 + 11'(BALL_H / 2) >= w_pad11 + 11'(2 * PADDLE_H / 3))
                            w_ydir = 1'b1;
`endif
                    end else if (r_xdir) begin
                        if (w_x11 + 11'(BALL_W) + w_vx11 >= 11'(SCREEN_W)) begin
                            w_s1    = 1'b1;
                            w_state = S_SCORED;
                        end else begin
                            w_x = r_x + 10'(r_vx);
                        end
                    end else begin
                        if (w_x11 < w_vx11) begin
                            w_s2    = 1'b1;
                            w_state = S_SCORED;
                        end else begin
                            w_x = r_x - 10'(r_vx);
                        end
                    end
                end
            end
            S_SCORED: begin
                if (i_frame_tick) begin
                    // A miss only happens while moving toward the missing side,
                    // so reversing x_dir sends the serve back the other way.
                    w_x     = X_CTR;
                    w_y     = Y_CTR;
                    w_vx    = VX_INIT;
                    w_xdir  = ~r_xdir;
                    w_cnt   = '0;
                    w_state = S_SERVE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rgb = i_visible
             && ({1'b0, i_pixel_x} >= w_x11) && ({1'b0, i_pixel_x} < w_x11 + 11'(BALL_W))
             && ({1'b0, i_pixel_y} >= w_y11) && ({1'b0, i_pixel_y} < w_y11 + 11'(BALL_H));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_x     <= X_CTR;
            r_y     <= Y_CTR;
            r_vx    <= VX_INIT;
            r_xdir  <= 1'b1;
            r_ydir  <= 1'b1;
            r_cnt   <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_rgb   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_vx    <= w_vx;
            r_xdir  <= w_xdir;
            r_ydir  <= w_ydir;
            r_cnt   <= w_cnt;
            r_s1    <= w_s1;
            r_s2    <= w_s2;
            r_rgb   <= w_rgb;
        end
    end

    assign o_r        = r_rgb;
    assign o_g        = r_rgb;
    assign o_b        = r_rgb;
    assign o_ball_x   = r_x;
    assign o_ball_y   = r_y;
    assign o_score_p1 = r_s1;
    assign o_score_p2 = r_s2;
    assign o_state    = r_state;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed scenarios followed by a
// randomised rally, all compared against an integer game model.
module tb_pong_ball_engine;
    localparam int SW = 640, SH = 480, BW = 8, BH = 10, PM = 30, PW = 10, PH = 50;
    localparam int VX0 = 2, VXM = 6, VY = 2, SF = 60;
    localparam int XC = (SW - BW) / 2, YC = (SH - BH) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, visible = 1'b0, serve = 1'b0;
    logic [9:0] px = '0, py = '0, p1y = '0, p2y = '0;
    logic       r, g, b, s1, s2;
    logic [9:0] bx, by;
    logic [1:0] st;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick),
        .i_pixel_x(px), .i_pixel_y(py), .i_visible(visible),
        .i_paddle1_y(p1y), .i_paddle2_y(p2y), .i_serve(serve),
        .o_r(r), .o_g(g), .o_b(b), .o_ball_x(bx), .o_ball_y(by),
        .o_score_p1(s1), .o_score_p2(s2), .o_state(st)
    );

    int checks = 0, errors = 0;
    // model state: position, speed, direction (1 = right / down), state, counter
    int mx, my, mvx, mxd, myd, mst, mcnt, m_right_missed;
    int es1, es2;
    logic obs_s1, obs_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = XC; my = YC; mvx = VX0; mxd = 1; myd = 1; mst = 0; mcnt = 0;
        es1 = 0; es2 = 0; m_right_missed = 0;
    endtask

    task automatic model_tick(input int pad1, input int pad2);
        int pad, ny, nyd, hit;
        es1 = 0; es2 = 0;
        if (mst == 1) begin
            if (mcnt == SF - 1) mst = 2; else mcnt++;
        end else if (mst == 2) begin
            pad = mxd ? pad2 : pad1;
            hit = (mxd ? (mx >= SW - PM - PW - BW) : (mx <= PM + PW))
                  && (my + BH > pad) && (my < pad + PH);
            ny = my; nyd = myd;
            if (myd) begin if (my + BH + VY >= SH) nyd = 0; else ny = my + VY; end
            else     begin if (my < VY) nyd = 1; else ny = my - VY; end
            if (hit) begin
                mxd = !mxd;
                mvx = (mvx + 1 > VXM) ? VXM : mvx + 1;
`ifdef PONG_BALL_SPIN_EN
                if (my + BH / 2 < pad + PH / 3) nyd = 0;
                else if (my + BH / 2 >= pad + 2 * PH / 3) nyd = 1;
`endif
            end else if (mxd && mx + BW + mvx >= SW) begin
                es1 = 1; mst = 3; m_right_missed = 1;
            end else if (!mxd && mx < mvx) begin
                es2 = 1; mst = 3; m_right_missed = 0;
            end else begin
                mx = mxd ? mx + mvx : mx - mvx;
            end
            my = ny; myd = nyd;
        end else if (mst == 3) begin
            // serve heads away from the side that just missed
            mx = XC; my = YC; mvx = VX0; mcnt = 0; mst = 1;
            mxd = m_right_missed ? 0 : 1;
        end
    endtask

    task automatic do_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        obs_s1 = s1; obs_s2 = s2;
        model_tick(int'(p1y), int'(p2y));
    endtask

    task automatic chk_model(input string tag);
        check({tag, "_x"}, 32'(bx), 32'(mx));
        check({tag, "_y"}, 32'(by), 32'(my));
        check({tag, "_st"}, 32'(st), 32'(mst));
        check({tag, "_s1"}, 32'(obs_s1), 32'(es1));
        check({tag, "_s2"}, 32'(obs_s2), 32'(es2));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0; visible = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic do_serve();
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
        if (mst == 0) begin mst = 1; mcnt = 0; end
    endtask

    function automatic logic [31:0] rgb_exp(input int x, input int y, input int v);
        return (v != 0 && x >= mx && x < mx + BW && y >= my && y < my + BH) ? 32'd7 : 32'd0;
    endfunction

    initial begin
        int hit, got, t, k0;
        int pxs[6] = '{316, 323, 324, 316, 315, 316};
        int pys[6] = '{235, 244, 235, 245, 235, 235};
        int vis[6] = '{1, 1, 1, 1, 1, 0};
        model_reset();
        #12;
        // reset state
        check("rst_x", 32'(bx), 316);
        check("rst_y", 32'(by), 235);
        check("rst_st", 32'(st), 0);
        check("rst_rgb", {29'd0, r, g, b}, 0);
        check("rst_s1", 32'(s1), 0);
        check("rst_s2", 32'(s2), 0);
        @(negedge clk); rst_n = 1'b1;

        // ticks in IDLE do nothing
        for (int i = 0; i < 3; i++) begin do_tick(); chk_model("idle"); end

        // serve: 60 ticks to PLAY, serve level ignored meanwhile
        do_serve();
        check("serve_st", 32'(st), 1);
        serve = 1'b1;
        for (int i = 0; i < SF; i++) begin
            do_tick();
            if (i == SF - 2) check("serve59_st", 32'(st), 1);
        end
        serve = 1'b0;
        check("play_st", 32'(st), 2);
        check("play_x0", 32'(bx), 316);
        do_tick();
        check("first_x", 32'(bx), 318);
        check("first_y", 32'(by), 237);
        chk_model("first");

        // right paddle tracking the ball: rebound at x = 592
        hit = 0;
        for (int k = 0; k < 200 && hit == 0; k++) begin
            p2y = (my >= 20) ? 10'(my - 20) : 10'd0;
            k0 = mxd;
            do_tick();
            chk_model("rally");
            if (k0 == 1 && mxd == 0) begin
                hit = 1;
                check("hit_x", 32'(bx), 592);
            end
        end
        check("hit_seen", 32'(hit), 1);
        do_tick();
        check("after_hit_x", 32'(bx), 589);
        chk_model("after_hit");

        // right miss from a fresh serve
        do_reset();
        do_serve();
        for (int i = 0; i < SF; i++) do_tick();
        got = 0;
        for (int k = 0; k < 400 && got == 0; k++) begin
            p2y = (my > 100) ? 10'd0 : 10'd400;
            do_tick();
            chk_model("miss");
            if (es1 == 1) begin
                got = 1;
                check("miss_x", 32'(bx), 630);
                check("miss_st", 32'(st), 3);
                @(negedge clk);
                check("miss_pulse_1cyc", 32'(s1), 0);
            end
        end
        check("miss_seen", 32'(got), 1);
        do_tick();
        check("scored_x", 32'(bx), 316);
        check("scored_st", 32'(st), 1);
        for (int i = 0; i < SF; i++) do_tick();
        do_tick();
        check("reserve_x", 32'(bx), 314);
        chk_model("reserve");

        // display window around the centred ball
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); px = 10'(pxs[i]); py = 10'(pys[i]); visible = vis[i][0];
            @(negedge clk);
            check("pix", {29'd0, r, g, b}, rgb_exp(pxs[i], pys[i], vis[i]));
        end
        check("pix_on", {29'd0, r, g, b}, 0);

        // asynchronous reset mid-play while drawing
        do_serve();
        for (int i = 0; i < SF + 5; i++) do_tick();
        @(negedge clk); px = 10'(mx); py = 10'(my); visible = 1'b1;
        @(negedge clk);
        check("arst_pre_rgb", {29'd0, r, g, b}, 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb", {29'd0, r, g, b}, 0);
        check("arst_st", 32'(st), 0);
        check("arst_x", 32'(bx), 316);
        check("arst_y", 32'(by), 235);
        model_reset();
        @(negedge clk); rst_n = 1'b1; visible = 1'b0;

        // randomised rally: random or ball-tracking paddles, periodic pixel probes
        do_serve();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = my + int'($urandom_range(0, 58)) - 48;
                p2y = 10'((t < 0) ? 0 : t);
            end else p2y = 10'($urandom_range(0, 430));
            if ($urandom_range(0, 1) == 1) begin
                t = my + int'($urandom_range(0, 58)) - 48;
                p1y = 10'((t < 0) ? 0 : t);
            end else p1y = 10'($urandom_range(0, 430));
            do_tick();
            chk_model("rnd");
            if (i % 8 == 0) begin
                t = mx + int'($urandom_range(0, 11)) - 2;
                k0 = my + int'($urandom_range(0, 13)) - 2;
                if (t < 0) t = 0;
                if (k0 < 0) k0 = 0;
                @(negedge clk); px = 10'(t); py = 10'(k0); visible = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                check("rnd_pix", {29'd0, r, g, b}, rgb_exp(t, k0, int'(visible)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
